// File: rtl/seq_detector.sv
// seq_detector: commits debounced 2-bit symbols and flags matches of the last SEQ_LEN symbols against PATTERN
module seq_detector #(
  parameter int                   SEQ_LEN    = 4,
  parameter logic [2*SEQ_LEN-1:0] PATTERN    = 8'b01_10_11_00,
  parameter logic [15:0]          STABLE_CYC = 16'd27000,
  parameter logic [23:0]          HOLD_CYC   = 24'd13500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det_en_n,
  input  logic [1:0] seq_data,
  output logic       sym_valid,
  output logic [1:0] last_sym,
  output logic       det_pulse,
  output logic       det_led,
  output logic [7:0] match_cnt
);
  localparam int CW = $clog2(SEQ_LEN + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SETTLE} state_t;
  state_t               state_q, state_d;
  logic [1:0]           ref_q, ref_d, cand_q, cand_d, last_sym_q, last_sym_d;
  logic [15:0]          stab_cnt_q, stab_cnt_d;
  logic [2*SEQ_LEN-1:0] sym_sr_q, sym_sr_d;
  logic [CW-1:0]        sym_cnt_q, sym_cnt_d;
  logic [23:0]          hold_cnt_q, hold_cnt_d;
  logic [7:0]           match_cnt_q, match_cnt_d;
  logic                 sym_valid_q, sym_valid_d, hit_q, hit_d, det_pulse_q, det_pulse_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ref_q       <= '0;
      cand_q      <= '0;
      last_sym_q  <= '0;
      stab_cnt_q  <= '0;
      sym_sr_q    <= '0;
      sym_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      match_cnt_q <= '0;
      sym_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      cand_q      <= cand_d;
      last_sym_q  <= last_sym_d;
      stab_cnt_q  <= stab_cnt_d;
      sym_sr_q    <= sym_sr_d;
      sym_cnt_q   <= sym_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      match_cnt_q <= match_cnt_d;
      sym_valid_q <= sym_valid_d;
      hit_q       <= hit_d;
      det_pulse_q <= det_pulse_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    cand_d      = cand_q;
    last_sym_d  = last_sym_q;
    stab_cnt_d  = stab_cnt_q;
    sym_sr_d    = sym_sr_q;
    sym_cnt_d   = sym_cnt_q;
    sym_valid_d = 1'b0;
    hit_d       = 1'b0;
    det_pulse_d = hit_q && !det_en_n;
    // a fresh hit reloads the LED timer even on the cycle it would expire
    hold_cnt_d  = det_pulse_d ? HOLD_CYC : (hold_cnt_q != '0) ? hold_cnt_q - 24'd1 : '0;
    match_cnt_d = match_cnt_q + 8'(det_pulse_d && match_cnt_q != 8'hff);
    if (det_en_n) begin
      state_d    = IDLE;
      sym_sr_d   = '0;
      sym_cnt_d  = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ref_d       = seq_data;
          match_cnt_d = '0;
          state_d     = WAIT;
        end
        WAIT: if (seq_data != ref_q) begin
          cand_d     = seq_data;
          stab_cnt_d = '0;
          state_d    = SETTLE;
        end
        SETTLE: begin
          if (seq_data == ref_q) state_d = WAIT;
          else if (seq_data != cand_q) begin
            cand_d     = seq_data;
            stab_cnt_d = '0;
          end else if (stab_cnt_q == STABLE_CYC - 16'd1) begin
            sym_sr_d    = {sym_sr_q[2*SEQ_LEN-3:0], cand_q};
            sym_cnt_d   = (sym_cnt_q == CW'(SEQ_LEN)) ? sym_cnt_q : sym_cnt_q + CW'(1);
            ref_d       = cand_q;
            last_sym_d  = cand_q;
            sym_valid_d = 1'b1;
            hit_d       = (sym_cnt_d == CW'(SEQ_LEN)) && (sym_sr_d == PATTERN);
            state_d     = WAIT;
          end else stab_cnt_d = stab_cnt_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign sym_valid = sym_valid_q;
  assign last_sym  = last_sym_q;
  assign det_pulse = det_pulse_q;
  assign det_led   = (hold_cnt_q == '0);
  assign match_cnt = match_cnt_q;
endmodule
